// File: rtl/mips_soc.sv
// mips_soc: switch-operand ALU with LED, 7-segment and UART result output.
// Define MIPS_UART_TX_EN to build the UART transmitter; otherwise uart_txd is tied 1.
module mips_soc #(
  parameter int SCAN_DIV = 12500,
  parameter int BAUD_DIV = 217
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  input  logic        uart_rxd,
  input  logic [7:0]  dip_switch0,
  input  logic [7:0]  dip_switch1,
  input  logic [7:0]  dip_switch2,
  input  logic [7:0]  dip_switch3,
  input  logic [7:0]  dip_switch4,
  input  logic [7:0]  dip_switch5,
  input  logic [7:0]  dip_switch6,
  input  logic [7:0]  dip_switch7,
  input  logic [7:0]  user_key,
  output logic        uart_txd,
  output logic [31:0] led_light,
  output logic [7:0]  digital_tube0,
  output logic [7:0]  digital_tube1,
  output logic [7:0]  digital_tube2,
  output logic [3:0]  digital_tube_sel0,
  output logic [3:0]  digital_tube_sel1,
  output logic        digital_tube_sel2
);

  localparam int SW = $clog2(SCAN_DIV + 1);

  logic [63:0]   sw_s1, sw_s2;
  logic [7:0]    key_s1, key_s2;
  logic [31:0]   r, r_nxt, a, b;
  logic [15:0]   r_hi;
  logic [2:0]    op;
  logic          op_v, run;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic          unused_ok;

  assign unused_ok = ^{uart_rxd};

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '0;
      key_s2 <= '0;
      r      <= '0;
      run    <= 1'b0;
    end else begin
      sw_s1  <= {dip_switch7, dip_switch6, dip_switch5, dip_switch4,
                 dip_switch3, dip_switch2, dip_switch1, dip_switch0};
      sw_s2  <= sw_s1;
      key_s1 <= user_key;
      key_s2 <= key_s1;
      run    <= 1'b1;
      if (op_v) r <= r_nxt;
    end
  end

  assign a = sw_s2[31:0];
  assign b = sw_s2[63:32];

  // lowest pressed key wins
  always_comb begin
    op_v = 1'b0;
    op   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!key_s2[i]) begin
        op_v = 1'b1;
        op   = i[2:0];
      end
    end
  end

  always_comb begin
    r_nxt = r;
    case (op)
      3'd0: r_nxt = a + b;
      3'd1: r_nxt = a - b;
      3'd2: r_nxt = a & b;
      3'd3: r_nxt = a | b;
      3'd4: r_nxt = a ^ b;
      3'd5: r_nxt = {31'd0, $signed(a) < $signed(b)};
      3'd6: r_nxt = a << b[4:0];
      3'd7: r_nxt = a >> b[4:0];
    endcase
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  assign r_hi              = r[31:16];
  assign led_light         = ~r;
  assign digital_tube_sel0 = 4'b0001 << idx;
  assign digital_tube_sel1 = 4'b0001 << idx;
  assign digital_tube_sel2 = run;
  assign digital_tube0 = run ? hex_seg(r[{idx, 2'b00} +: 4]) : 8'hFF;
  assign digital_tube1 = run ? hex_seg(r_hi[{idx, 2'b00} +: 4]) : 8'hFF;
  assign digital_tube2 = (run && op_v) ? hex_seg({1'b0, op}) : 8'hFF;

`ifdef MIPS_UART_TX_EN
  localparam int BW = $clog2(BAUD_DIV + 1);

  typedef enum logic {TX_IDLE, TX_SEND} tx_st_t;

  tx_st_t        tx_st;
  logic [BW-1:0] tx_cnt;
  logic [8:0]    tx_sh;
  logic [23:0]   tx_buf;
  logic [3:0]    tx_bit;
  logic [1:0]    tx_byte, warm;
  logic          tx_pend, tx_set, txd_q;

  // warm==2 marks the edge where R first reflects the sampled inputs
  assign tx_set   = (op_v && (r_nxt != r)) || (warm == 2'd2);
  assign uart_txd = txd_q;

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      tx_st   <= TX_IDLE;
      tx_cnt  <= '0;
      tx_sh   <= '1;
      tx_buf  <= '0;
      tx_bit  <= 4'd0;
      tx_byte <= 2'd0;
      warm    <= 2'd0;
      tx_pend <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      if (warm != 2'd3) warm <= warm + 2'd1;
      tx_pend <= tx_set | (tx_pend & (tx_st != TX_IDLE));
      case (tx_st)
        TX_IDLE: begin
          if (tx_pend) begin
            tx_st   <= TX_SEND;
            tx_sh   <= {1'b1, r[31:24]};
            tx_buf  <= r[23:0];
            tx_byte <= 2'd0;
            tx_bit  <= 4'd0;
            tx_cnt  <= '0;
            txd_q   <= 1'b0;
          end
        end
        TX_SEND: begin
          if (tx_cnt != BW'(BAUD_DIV - 1)) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt <= '0;
            if (tx_bit != 4'd9) begin
              txd_q  <= tx_sh[0];
              tx_sh  <= {1'b1, tx_sh[8:1]};
              tx_bit <= tx_bit + 4'd1;
            end else if (tx_byte != 2'd3) begin
              tx_sh   <= {1'b1, tx_buf[23:16]};
              tx_buf  <= {tx_buf[15:0], 8'h00};
              tx_byte <= tx_byte + 2'd1;
              tx_bit  <= 4'd0;
              txd_q   <= 1'b0;
            end else begin
              tx_st <= TX_IDLE;
            end
          end
        end
      endcase
    end
  end
`else
  assign uart_txd = 1'b1;
`endif

endmodule

// File: tb/tb_mips_soc.sv
// tb_mips_soc: randomized ALU checks against a reference model,
// display scan, reset state and UART burst decoding.
module tb_mips_soc;
  localparam int SD = 10;
  localparam int BD = 8;
  localparam logic [7:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 0;
  logic        rstn = 0;
  logic        rxd = 1;
  logic [7:0]  sw [8];
  logic [7:0]  key;
  logic        txd;
  logic [31:0] led;
  logic [7:0]  t0, t1, t2;
  logic [3:0]  s0, s1;
  logic        s2;

  int          n_run = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          frame_err = 0;
  logic [31:0] exp_r = 0;
  logic [7:0]  rxq [$];

  mips_soc #(.SCAN_DIV(SD), .BAUD_DIV(BD)) mips (
    .clk_in(clk), .sys_rstn(rstn), .uart_rxd(rxd),
    .dip_switch0(sw[0]), .dip_switch1(sw[1]),
    .dip_switch2(sw[2]), .dip_switch3(sw[3]),
    .dip_switch4(sw[4]), .dip_switch5(sw[5]),
    .dip_switch6(sw[6]), .dip_switch7(sw[7]),
    .user_key(key), .uart_txd(txd), .led_light(led),
    .digital_tube0(t0), .digital_tube1(t1), .digital_tube2(t2),
    .digital_tube_sel0(s0), .digital_tube_sel1(s1),
    .digital_tube_sel2(s2));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn)
    if (!rstn) cyc <= 0;
    else cyc <= cyc + 1;

  // UART receiver sampling mid-bit
  always begin
    logic [7:0] v;
    @(negedge txd);
    if (rstn) begin
      repeat (BD / 2) @(negedge clk);
      if (txd == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          v[i] = txd;
        end
        repeat (BD) @(negedge clk);
        if (txd == 1'b1) rxq.push_back(v);
        else frame_err++;
      end
    end
  end

  function automatic int ref_op(input logic [7:0] k);
    for (int i = 0; i < 8; i++)
      if (k[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] a, b,
                                        input logic [7:0] k,
                                        input logic [31:0] prev);
    case (ref_op(k))
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6: return a << b[4:0];
      7: return a >> b[4:0];
      default: return prev;
    endcase
  endfunction

  task automatic set_in(input logic [31:0] a, b, input logic [7:0] k);
    for (int i = 0; i < 4; i++) begin
      sw[i]     = a[8*i +: 8];
      sw[i + 4] = b[8*i +: 8];
    end
    key = k;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    set_in(0, 0, 8'hFF);
    repeat (2) @(negedge clk);
    n_run++;
    if (led !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL rst_led: got %h want ffffffff", led);
    end
    n_run++;
    if (txd !== 1'b1) begin
      n_fail++; $display("FAIL rst_txd: got %b want 1", txd);
    end
    n_run++;
    if ({t0, t1, t2} !== 24'hFFFFFF) begin
      n_fail++; $display("FAIL rst_tubes: got %h want ffffff", {t0, t1, t2});
    end
    n_run++;
    if ({s0, s1, s2} !== 9'b0001_0001_0) begin
      n_fail++; $display("FAIL rst_sel: got %b want 000100010", {s0, s1, s2});
    end
    exp_r = 0;
  endtask

  task automatic test_add();
    set_in(32'h01010307, 32'h01060203, 8'hFE);
    @(negedge clk);
    rstn = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_run++;
    if (led !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL add_early: got %h want ffffffff", led);
    end
    @(posedge clk);
    @(negedge clk);
    exp_r = 32'h0207050A;
    n_run++;
    if (led !== 32'hFDF8FAF5) begin
      n_fail++; $display("FAIL add_led: got %h want fdf8faf5", led);
    end
    n_run++;
    if (t2 !== 8'hC0 || s2 !== 1'b1) begin
      n_fail++; $display("FAIL add_tube2: got %h/%b want c0/1", t2, s2);
    end
  endtask

  task automatic test_ops();
    logic [31:0] va [5] = '{32'h01010307, 32'h01010307, 32'h01010307,
                            32'h80000000, 32'h80000000};
    logic [31:0] vb [5] = '{32'h01060203, 32'h01060203, 32'h01060203,
                            32'h00000001, 32'h00000001};
    logic [7:0]  vk [5] = '{8'hFD, 8'hFB, 8'hBF, 8'hDF, 8'h7F};
    logic [31:0] vr [5] = '{32'hFFFB0104, 32'h01000203, 32'h08081838,
                            32'h00000001, 32'h40000000};
    for (int i = 0; i < 5; i++) begin
      set_in(va[i], vb[i], vk[i]);
      settle();
      n_run++;
      if (led !== ~vr[i]) begin
        n_fail++;
        $display("FAIL op_fixed%0d: got %h want %h", i, ~led, vr[i]);
      end
      exp_r = vr[i];
    end
    for (int i = 0; i < 40; i++) begin
      int          op = $urandom_range(0, 8);
      logic [7:0]  k = 8'($urandom);
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      int          eop;
      if (op == 8) k = 8'hFF;
      else begin
        k = k | 8'((1 << op) - 1);
        k[op] = 1'b0;
      end
      set_in(a, b, k);
      settle();
      exp_r = ref_r(a, b, k, exp_r);
      eop = ref_op(k);
      chk($sformatf("op_rand%0d", i), ~led, exp_r);
      chk($sformatf("op_tube2_%0d", i), {24'd0, t2},
          {24'd0, (eop < 0) ? 8'hFF : FONT[eop]});
    end
  endtask

  task automatic test_display();
    set_in(32'h01010307, 32'h01060203, 8'hFE);
    settle();
    exp_r = 32'h0207050A;
    for (int st = 0; st < 4; st++) begin
      int ix = (cyc / SD) % 4;
      n_run++;
      if (s0 !== 4'(1 << ix) || s1 !== 4'(1 << ix)) begin
        n_fail++;
        $display("FAIL disp_sel%0d: got %b/%b want idx %0d", st, s0, s1, ix);
      end
      n_run++;
      if (t0 !== FONT[(exp_r >> (4 * ix)) & 15] ||
          t1 !== FONT[(exp_r >> (16 + 4 * ix)) & 15]) begin
        n_fail++;
        $display("FAIL disp_seg%0d: got %h/%h idx %0d", st, t0, t1, ix);
      end
      repeat (SD) @(negedge clk);
    end
  endtask

  task automatic test_uart();
`ifdef MIPS_UART_TX_EN
    logic [7:0] want [8] = '{8'h02, 8'h07, 8'h05, 8'h0A,
                             8'h01, 8'h00, 8'h02, 8'h03};
    int t;
    rstn = 0;
    set_in(32'h01010307, 32'h01060203, 8'hFE);
    rxq.delete();
    frame_err = 0;
    @(negedge clk);
    rstn = 1;
    for (t = 0; t < 3000 && rxq.size() < 2; t++) @(negedge clk);
    set_in(32'h01010307, 32'h01060203, 8'hFD);
    repeat (20) @(negedge clk);
    set_in(32'h01010307, 32'h01060203, 8'hFB);
    for (t = 0; t < 6000 && rxq.size() < 8; t++) @(negedge clk);
    chk("uart_count", rxq.size(), 8);
    for (int i = 0; i < 8 && i < rxq.size(); i++)
      chk($sformatf("uart_byte%0d", i), {24'd0, rxq[i]}, {24'd0, want[i]});
    repeat (50 * BD) @(negedge clk);
    chk("uart_coalesce", rxq.size(), 8);
    chk("uart_frame", frame_err, 0);
    set_in(32'h00000005, 32'h00000009, 8'hFE);
    for (t = 0; t < 500 && txd !== 1'b0; t++) @(negedge clk);
    chk("uart_start", {31'd0, txd}, 0);
    repeat (3 * BD) @(negedge clk);
    #2 rstn = 0;
    #1;
    chk("uart_abort", {31'd0, txd}, 1);
`else
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      set_in($urandom, $urandom, 8'(8'hFE << (i % 3)));
      repeat (4 * BD) begin
        @(negedge clk);
        if (txd !== 1'b1) bad++;
      end
    end
    chk("uart_tied", bad, 0);
`endif
  endtask

  initial begin
    set_in(0, 0, 8'hFF);
    test_reset();
    test_add();
    test_ops();
    test_display();
    test_uart();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
